// File: rtl/pixel_merge_n.sv
// pixel_merge_n
//   Merges N_CH independent pixel streams into one output stream. Each channel
//   has its own first-word-fall-through FIFO. Once every FIFO holds a word, one
//   word is popped from each of them together (a "set"). The set is then used
//   according to mode:
//     SELECT (0, 3)  : forward the word of channel sel (sel >= N_CH -> ch0)
//     AVG (1)        : per-field RGB565 average, truncated, no carry between fields
//     INTERLEAVE (2) : emit channel 0..N_CH-1 words on consecutive cycles
//   Output latency is two edges from the write that completes a set.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   per-channel write strobe
//   in_data    channel k at [k*PIX_W +: PIX_W]
//   mode       merge mode, sampled only while the sequencer is idle
//   sel        source channel for SELECT, sampled only while idle
//   flush      synchronous clear of all FIFOs and pending output
//   err_clr    synchronous clear of the sticky overflow flags
//   out_valid  output strobe (no backpressure)
//   out_data   merged pixel, holds its value while out_valid is low
//   err        sticky per-channel overflow flags
//   max_level  highest FIFO occupancy, one edge behind the FIFOs
//
// Sequencer states
//   state | meaning
//   IDLE  | waiting for a complete set; pops happen only here
//   BURST | emitting a latched INTERLEAVE set, one word per cycle

module pixel_merge_n #(
    parameter int N_CH  = 2,
    parameter int PIX_W = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*PIX_W-1:0]    in_data,
    input  logic [1:0]               mode,
    input  logic [1:0]               sel,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic                     out_valid,
    output logic [PIX_W-1:0]         out_data,
    output logic [N_CH-1:0]          err,
    output logic [$clog2(DEPTH):0]   max_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int SH = $clog2(N_CH);
    localparam int IW = (SH > 0) ? SH : 1;

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [1:0] MODE_AVG = 2'd1;
    localparam logic [1:0] MODE_ILV = 2'd2;

    // FIFO storage and status
    logic [PIX_W-1:0] mem_q    [N_CH][DEPTH];
    logic [AW:0]      wr_ptr_q [N_CH];
    logic [AW:0]      rd_ptr_q [N_CH];
    logic [AW:0]      cnt      [N_CH];
    logic [PIX_W-1:0] head     [N_CH];
    logic [N_CH-1:0]  full;
    logic [N_CH-1:0]  empty;
    logic [N_CH-1:0]  wr_en;
    logic [N_CH-1:0]  ovf;
    logic             set_ready;
    logic             pop;

    // Sequencer and output pipeline
    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [PIX_W-1:0] set_q [N_CH];
    logic             set_load;
    logic [PIX_W-1:0] stage_q, stage_d;
    logic             stage_vld_q, stage_vld_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_data_q, out_data_d;
    logic [N_CH-1:0]  err_q, err_d;
    logic [AW:0]      max_level_q, max_level_d;

    logic [PIX_W-1:0] sel_word;
    logic [PIX_W-1:0] avg_word;
    logic [PIX_W-1:0] burst_word;
    logic [15:0]      px;
    logic [6:0]       sum_r;
    logic [7:0]       sum_g;
    logic [6:0]       sum_b;
    logic [15:0]      avg16;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cnt[k]   = wr_ptr_q[k] - rd_ptr_q[k];
            full[k]  = (cnt[k] == FULL_CNT);
            empty[k] = (cnt[k] == '0);
            head[k]  = mem_q[k][rd_ptr_q[k][AW-1:0]];
        end
    end

    assign set_ready = (state_q == IDLE) && (empty == '0);
    assign pop       = set_ready && !flush;

    // A full FIFO still accepts a word when it is being popped on the same edge;
    // the write lands in the slot the read pointer is vacating.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            wr_en[k] = in_valid[k] && !flush && (!full[k] || pop);
            ovf[k]   = in_valid[k] && !flush && full[k] && !pop;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (wr_en[k]) begin
                mem_q[k][wr_ptr_q[k][AW-1:0]] <= in_data[k*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < N_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (wr_en[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
                if (pop)      rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
            end
        end
    end

    // Field sums are kept wide enough for N_CH=4 so no field overflows into
    // its neighbour; the shift then truncates each field independently.
    always_comb begin
        sel_word   = head[0];
        burst_word = set_q[0];
        px         = '0;
        sum_r      = '0;
        sum_g      = '0;
        sum_b      = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(sel) == k)   sel_word   = head[k];
            if (int'(idx_q) == k) burst_word = set_q[k];
            px    = 16'(head[k]);
            sum_r = sum_r + 7'(px[15:11]);
            sum_g = sum_g + 8'(px[10:5]);
            sum_b = sum_b + 7'(px[4:0]);
        end
        avg16    = {5'(sum_r >> SH), 6'(sum_g >> SH), 5'(sum_b >> SH)};
        avg_word = PIX_W'(avg16);
    end

    // SELECT/AVG results go through stage_q so that every mode, including the
    // first INTERLEAVE word, appears two edges after the completing write.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        set_load    = 1'b0;
        stage_d     = stage_q;
        stage_vld_d = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (stage_vld_q) begin
            out_valid_d = 1'b1;
            out_data_d  = stage_q;
        end

        if (state_q == BURST) begin
            out_valid_d = 1'b1;
            out_data_d  = burst_word;
            if (int'(idx_q) == N_CH - 1) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (pop) begin
            case (mode)
                MODE_AVG: begin
                    stage_d     = avg_word;
                    stage_vld_d = 1'b1;
                end
                MODE_ILV: begin
                    state_d  = BURST;
                    idx_d    = '0;
                    set_load = 1'b1;
                end
                default: begin
                    stage_d     = sel_word;
                    stage_vld_d = 1'b1;
                end
            endcase
        end

        if (flush) begin
            state_d     = IDLE;
            idx_d       = '0;
            stage_vld_d = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end
    end

    always_comb begin
        err_d = (err_q & ~{N_CH{err_clr}}) | ovf;
    end

    always_comb begin
        max_level_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cnt[k] > max_level_d) max_level_d = cnt[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= '0;
            max_level_q <= '0;
            for (int k = 0; k < N_CH; k++) set_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            max_level_q <= max_level_d;
            if (set_load) begin
                for (int k = 0; k < N_CH; k++) set_q[k] <= head[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign max_level = max_level_q;

endmodule

// File: tb/tb_pixel_merge_n.sv
module tb_pixel_merge_n;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Drive variables; instance 0 is N_CH=2, instance 1 is N_CH=4
    logic [3:0]  dv     [2];
    logic [15:0] dd     [2][4];
    logic [1:0]  dmode  [2];
    logic [1:0]  dsel   [2];
    logic        dflush [2];
    logic        dclr   [2];

    logic [1:0]  a_valid;
    logic [31:0] a_data;
    logic [1:0]  a_mode, a_sel;
    logic        a_flush, a_clr;
    logic        a_ov;
    logic [15:0] a_od;
    logic [1:0]  a_err;
    logic [4:0]  a_ml;

    logic [3:0]  b_valid;
    logic [63:0] b_data;
    logic [1:0]  b_mode, b_sel;
    logic        b_flush, b_clr;
    logic        b_ov;
    logic [15:0] b_od;
    logic [3:0]  b_err;
    logic [4:0]  b_ml;

    assign a_valid = dv[0][1:0];
    assign a_data  = {dd[0][1], dd[0][0]};
    assign a_mode  = dmode[0];
    assign a_sel   = dsel[0];
    assign a_flush = dflush[0];
    assign a_clr   = dclr[0];
    assign b_valid = dv[1];
    assign b_data  = {dd[1][3], dd[1][2], dd[1][1], dd[1][0]};
    assign b_mode  = dmode[1];
    assign b_sel   = dsel[1];
    assign b_flush = dflush[1];
    assign b_clr   = dclr[1];

    pixel_merge_n #(.N_CH(2), .PIX_W(16), .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data),
        .mode(a_mode), .sel(a_sel), .flush(a_flush), .err_clr(a_clr),
        .out_valid(a_ov), .out_data(a_od), .err(a_err), .max_level(a_ml)
    );

    pixel_merge_n #(.N_CH(4), .PIX_W(16), .DEPTH(DEPTH)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data),
        .mode(b_mode), .sel(b_sel), .flush(b_flush), .err_clr(b_clr),
        .out_valid(b_ov), .out_data(b_od), .err(b_err), .max_level(b_ml)
    );

    // Reference model: word queues per channel plus a time-ordered list of
    // scheduled outputs (edge number, data).
    logic [15:0] mq   [2][4][$];
    int          st   [2][$];
    logic [15:0] sdat [2][$];
    int          busy [2];
    logic [3:0]  merr [2];
    logic        mov  [2];
    logic [15:0] mout [2];
    int          mmax [2];
    int          edge_n;

    int n_checks, n_errors;
    int a_pulses, b_pulses, seen_0110, snap;
    int prob [2][4];
    logic [15:0] ilv [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) mq[d][k].delete();
            st[d].delete();
            sdat[d].delete();
            busy[d] = 0;
            merr[d] = '0;
            mov[d]  = 1'b0;
            mout[d] = '0;
            mmax[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int n, mx, s, r, g, b;
            logic ready;
            logic [3:0] ovf;
            logic [15:0] w [4];
            n  = (d == 0) ? 2 : 4;
            mx = 0;
            for (int k = 0; k < n; k++) if (mq[d][k].size() > mx) mx = mq[d][k].size();
            mmax[d] = mx;
            ovf     = '0;
            mov[d]  = 1'b0;
            if (dflush[d]) begin
                for (int k = 0; k < 4; k++) mq[d][k].delete();
                st[d].delete();
                sdat[d].delete();
                busy[d] = 0;
            end else begin
                if (st[d].size() > 0 && st[d][0] == edge_n) begin
                    mov[d]  = 1'b1;
                    mout[d] = sdat[d].pop_front();
                    void'(st[d].pop_front());
                end
                ready = (busy[d] == 0);
                for (int k = 0; k < n; k++) if (mq[d][k].size() == 0) ready = 1'b0;
                if (busy[d] > 0) busy[d]--;
                if (ready) begin
                    for (int k = 0; k < n; k++) w[k] = mq[d][k].pop_front();
                    if (dmode[d] == 2'd1) begin
                        r = 0; g = 0; b = 0;
                        for (int k = 0; k < n; k++) begin
                            r += int'(w[k][15:11]);
                            g += int'(w[k][10:5]);
                            b += int'(w[k][4:0]);
                        end
                        st[d].push_back(edge_n + 1);
                        sdat[d].push_back(16'((r / n) * 2048 + (g / n) * 32 + (b / n)));
                    end else if (dmode[d] == 2'd2) begin
                        for (int k = 0; k < n; k++) begin
                            st[d].push_back(edge_n + 1 + k);
                            sdat[d].push_back(w[k]);
                        end
                        busy[d] = n;
                    end else begin
                        s = (int'(dsel[d]) < n) ? int'(dsel[d]) : 0;
                        st[d].push_back(edge_n + 1);
                        sdat[d].push_back(w[s]);
                    end
                end
                for (int k = 0; k < n; k++) begin
                    if (dv[d][k]) begin
                        if (mq[d][k].size() < DEPTH) mq[d][k].push_back(dd[d][k]);
                        else ovf[k] = 1'b1;
                    end
                end
            end
            merr[d] = (merr[d] & ~{4{dclr[d]}}) | ovf;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        edge_n++;
        #1;
        chk("a_valid", 32'(a_ov), 32'(mov[0]));
        chk("a_data",  32'(a_od), 32'(mout[0]));
        chk("a_err",   32'(a_err), 32'(merr[0][1:0]));
        chk("a_max",   32'(a_ml), 32'(mmax[0]));
        chk("b_valid", 32'(b_ov), 32'(mov[1]));
        chk("b_data",  32'(b_od), 32'(mout[1]));
        chk("b_err",   32'(b_err), 32'(merr[1]));
        chk("b_max",   32'(b_ml), 32'(mmax[1]));
        if (a_ov) a_pulses++;
        if (b_ov) b_pulses++;
        if (a_ov && a_od == 16'h0110) seen_0110++;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            dv[d]     = '0;
            dflush[d] = 1'b0;
            dclr[d]   = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; edge_n = 0;
        a_pulses = 0; b_pulses = 0; seen_0110 = 0;
        ilv[0] = 16'hAAAA; ilv[1] = 16'hBBBB; ilv[2] = 16'hCCCC; ilv[3] = 16'hDDDD;
        for (int d = 0; d < 2; d++) begin
            dmode[d] = 2'd0;
            dsel[d]  = 2'd0;
            for (int k = 0; k < 4; k++) dd[d][k] = '0;
        end
        idle_inputs();
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_a_valid", 32'(a_ov), 32'd0);
        chk("rst_a_err",   32'(a_err), 32'd0);
        chk("rst_a_max",   32'(a_ml), 32'd0);
        chk("rst_b_valid", 32'(b_ov), 32'd0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // SELECT, sel=1: ch0 at edge 0, ch1 at edge 3, output after edge 5
        dsel[0] = 2'd1;
        dv[0] = 4'b0001; dd[0][0] = 16'h1111; tick();
        dv[0] = '0; tick(); tick();
        dv[0] = 4'b0010; dd[0][1] = 16'h2222; tick();
        dv[0] = '0; tick();
        chk("sel_early", 32'(a_ov), 32'd0);
        tick();
        chk("sel_valid", 32'(a_ov), 32'd1);
        chk("sel_data",  32'(a_od), 32'h2222);
        tick();

        // AVG, N_CH=2
        dmode[0] = 2'd1;
        dv[0] = 4'b0011; dd[0][0] = 16'hF800; dd[0][1] = 16'h07E0; tick();
        dv[0] = 4'b0011; dd[0][0] = 16'hFFFF; dd[0][1] = 16'h0000; tick();
        dv[0] = '0; tick();
        chk("avg1_data", 32'(a_od), 32'h7BE0);
        tick();
        chk("avg2_data", 32'(a_od), 32'h7BEF);
        tick();
        chk("avg_hold_valid", 32'(a_ov), 32'd0);
        chk("avg_hold_data",  32'(a_od), 32'h7BEF);

        // INTERLEAVE, N_CH=4, mode switched to SELECT mid-burst
        dmode[1] = 2'd2;
        dv[1] = 4'hF;
        for (int k = 0; k < 4; k++) dd[1][k] = ilv[k];
        tick();
        dv[1] = '0; tick();
        dmode[1] = 2'd0; dsel[1] = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ilv_valid", 32'(b_ov), 32'd1);
            chk("ilv_data",  32'(b_od), 32'(ilv[i]));
        end
        tick();
        chk("ilv_end", 32'(b_ov), 32'd0);

        // Overflow: 17 writes to ch0, ch1 idle
        dmode[0] = 2'd0; dsel[0] = 2'd0;
        for (int i = 0; i < 17; i++) begin
            dv[0] = 4'b0001; dd[0][0] = 16'(16'h0100 + i); tick();
        end
        dv[0] = '0;
        chk("ovf_err", 32'(a_err), 32'h1);
        chk("ovf_max", 32'(a_ml), 32'd16);

        // Flush with 5 queued words and a simultaneous write; err must survive
        dflush[0] = 1'b1; tick(); dflush[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dv[0] = 4'b0001; dd[0][0] = 16'(16'h0200 + i); tick();
        end
        dflush[0] = 1'b1; dv[0] = 4'b0011; dd[0][0] = 16'h0300; dd[0][1] = 16'h0301; tick();
        dflush[0] = 1'b0; dv[0] = '0;
        snap = a_pulses;
        for (int i = 0; i < 4; i++) tick();
        chk("flush_pulses", 32'(a_pulses - snap), 32'd0);
        chk("flush_max",    32'(a_ml), 32'd0);
        chk("flush_err",    32'(a_err), 32'h1);

        dclr[0] = 1'b1; tick(); dclr[0] = 1'b0;
        chk("errclr", 32'(a_err), 32'h0);

        // Refill to overflow, clear, then a write to a full FIFO during a pop
        for (int i = 0; i < 17; i++) begin
            dv[0] = 4'b0001; dd[0][0] = 16'(16'h0100 + i); tick();
        end
        dv[0] = '0;
        dclr[0] = 1'b1; tick(); dclr[0] = 1'b0;
        dv[0] = 4'b0010; dd[0][1] = 16'h5555; tick();
        dv[0] = 4'b0001; dd[0][0] = 16'h0AAA; tick();
        dv[0] = '0; tick();
        chk("full_pop_err", 32'(a_err), 32'h0);
        chk("full_pop_data", 32'(a_od), 32'h0100);
        for (int i = 0; i < 16; i++) begin
            dv[0] = 4'b0010; dd[0][1] = 16'(16'h0600 + i); tick();
        end
        dv[0] = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("drop_never_out", 32'(seen_0110), 32'd0);
        chk("drain_last", 32'(a_od), 32'h0AAA);

        // Reset in the middle of an INTERLEAVE burst
        dmode[1] = 2'd2;
        dv[1] = 4'hF;
        for (int k = 0; k < 4; k++) dd[1][k] = 16'(16'h0E00 + k);
        tick();
        dv[1] = '0; tick();
        tick();
        chk("burst_w0", 32'(b_od), 32'h0E00);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(b_ov), 32'd0);
        model_reset();
        tick();
        #2 rst = 1'b0;
        snap = b_pulses;
        for (int i = 0; i < 8; i++) tick();
        chk("rst_no_words", 32'(b_pulses - snap), 32'd0);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) begin
                for (int d = 0; d < 2; d++)
                    for (int k = 0; k < 4; k++) prob[d][k] = $urandom_range(10, 95);
            end
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    dv[d][k] = ($urandom_range(0, 99) < prob[d][k]);
                    dd[d][k] = 16'($urandom());
                end
                if ($urandom_range(0, 15) == 0) dmode[d] = 2'($urandom_range(0, 3));
                dsel[d]   = 2'($urandom_range(0, 3));
                dflush[d] = ($urandom_range(0, 59) == 0);
                dclr[d]   = ($urandom_range(0, 29) == 0);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_merge_n.md
PIXEL_MERGE_N -- requirements
Module: pixel_merge_n

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of input pixel streams; legal values 2 or 4.
REQ-002 SHALL have parameter PIX_W, default 16, pixel word width; AVG mode requires PIX_W = 16 (RGB565).
REQ-003 SHALL have parameter DEPTH, default 16, per-channel FIFO depth in words; power of two, at least 4.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  N_CH  per-channel pixel strobe.
REQ-007 SHALL have port in_data  input  N_CH*PIX_W  channel k at bits [k*PIX_W +: PIX_W].
REQ-008 SHALL have port mode  input  2  0=SELECT, 1=AVG, 2=INTERLEAVE, 3=treated as SELECT.
REQ-009 SHALL have port sel  input  2  source channel for SELECT; values >= N_CH select channel 0.
REQ-010 SHALL have port flush  input  1  synchronous clear of all FIFOs (driven at frame vsync).
REQ-011 SHALL have port err_clr  input  1  synchronous clear of the sticky error flags.
REQ-012 SHALL have port out_valid  output  1  output pixel strobe; no backpressure.
REQ-013 SHALL have port out_data  output  PIX_W  merged pixel.
REQ-014 SHALL have port err  output  N_CH  sticky per-channel overflow flags.
REQ-015 SHALL have port max_level  output  clog2(DEPTH)+1  highest current FIFO occupancy.

Function
REQ-016 SHALL use one first-word-fall-through FIFO per channel; in_valid[k] writes in_data word k.
REQ-017 SHALL drop a word offered to a full FIFO and set err[k] on the following edge, unless a pop of that FIFO occurs in the same cycle, in which case the write SHALL succeed.
REQ-018 SHALL define "set ready" as every FIFO non-empty while the sequencer is IDLE.
REQ-019 SHALL, in SELECT, pop one word from every FIFO on set ready and register the sel word.
REQ-020 SHALL, in AVG, pop all FIFOs and output the field-wise sums of R[15:11], G[10:5], B[4:0], each shifted right by log2(N_CH) with truncation and no cross-field carry.
REQ-021 SHALL, in INTERLEAVE, pop all FIFOs, latch the set, and emit channel 0..N_CH-1 words on N_CH consecutive cycles.
REQ-022 SHALL implement the sequencer states IDLE and BURST: IDLE->BURST on set ready in INTERLEAVE; BURST->IDLE after the word of channel N_CH-1; no pop occurs in BURST.
REQ-023 SHALL sample mode and sel only in IDLE; a change during BURST takes effect after the burst.
REQ-024 SHALL assert out_valid exactly 2 edges after the edge writing the last missing word of a set (SELECT/AVG, and the first INTERLEAVE word).
REQ-025 SHALL hold out_data at its last value while out_valid is 0.
REQ-026 SHALL, on flush, empty all FIFOs, return the sequencer to IDLE, and deassert out_valid on the next edge; flush has priority over simultaneous writes and pops, and leaves err unchanged.
REQ-027 SHALL, with err_clr and a new overflow in the same cycle, leave err[k] set.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-029 SHALL update max_level one edge after the occupancy changes.

Reset
REQ-030 SHALL, while rst is high, asynchronously clear the FIFOs, sequencer (IDLE), out_valid, out_data, err, and max_level to 0.
REQ-031 SHALL discard a BURST or set interrupted by reset; the first set after release is built only from post-reset writes.

Verification
REQ-032 SHALL check SELECT, N_CH=2, sel=1: ch0 writes 0x1111 at edge 0, ch1 writes 0x2222 at edge 3 -> out_valid=1 with out_data=0x2222 at edge 5.
REQ-033 SHALL check AVG, N_CH=2: inputs 0xF800 and 0x07E0 -> out_data=0x7BE0; inputs 0xFFFF and 0x0000 -> out_data=0x7BEF.
REQ-034 SHALL check INTERLEAVE, N_CH=4: one set A,B,C,D -> out_valid high for 4 consecutive cycles with A,B,C,D in order; a mode change to SELECT mid-burst does not alter the burst.
REQ-035 SHALL check DEPTH=16: 17 writes to ch0 with ch1 idle -> err=2'b01, max_level=16, and the 17th word is never output.
REQ-036 SHALL check that flush asserted with 5 words queued plus a simultaneous write -> all FIFOs empty, max_level=0, no out_valid, and err unchanged.
REQ-037 SHALL check that rst pulsed mid-INTERLEAVE burst -> out_valid=0 immediately (asynchronously) and no remaining burst words appear after release.
